// File: rtl/at_script_sequencer_pkg.sv
// at_seq_pkg: state encoding, ASCII constants and script base addressing for the AT sequencer
package at_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SEND     = 3'd2,
        WAIT_RSP = 3'd3,
        NEXT     = 3'd4,
        DONE     = 3'd5,
        FAIL     = 3'd6
    } state_t;

    localparam logic [7:0] NUL   = 8'h00;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] COMMA = 8'h2C;
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_R  = 8'h52;

    // Reply tails matched by the 4-byte receive window; "OR\r\n" is the end of "ERROR\r\n"
    localparam logic [31:0] RSP_OK  = {CH_O, CH_K, CR, LF};
    localparam logic [31:0] RSP_ERR = {CH_O, CH_R, CR, LF};

    function automatic int script_base(int sel, int depth, int num);
        return sel * (depth / num);
    endfunction

endpackage

// File: rtl/at_script_sequencer_if.sv
// at_script_sequencer_if: control, UART tx/rx and status signals of the AT script sequencer
//   start/script_sel        : run request and script index
//   tx_data/tx_valid/tx_ready : byte stream to the UART transmitter
//   rx_data/rx_valid        : byte strobe from the UART receiver
//   busy/done/fail          : run status
//   msg_no/msg_no_valid     : captured message index
interface at_script_sequencer_if #(
    parameter int SEL_W = 2
);
    logic             start;
    logic [SEL_W-1:0] script_sel;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             fail;
    logic [7:0]       msg_no;
    logic             msg_no_valid;

    modport master (
        output start, script_sel, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, busy, done, fail, msg_no, msg_no_valid
    );

    modport slave (
        input  start, script_sel, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, busy, done, fail, msg_no, msg_no_valid
    );
endinterface

// File: rtl/at_cmd_rom.sv
// at_cmd_rom: synchronous single-port command ROM, DEPTH x 8, contents from the INIT image
//   clk  : clock
//   addr : read address, data appears one cycle later
//   data : registered read data
//   INIT : byte i at bits [8*i +: 8]
module at_cmd_rom #(
    parameter int                 DEPTH = 128,
    parameter int                 AW    = $clog2(DEPTH),
    parameter logic [DEPTH*8-1:0] INIT  = '0
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data
);
    logic [7:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_init
        assign mem[i] = INIT[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        data <= mem[addr];
    end
endmodule

// File: rtl/at_script_sequencer.sv
// at_script_sequencer: plays NUL-terminated AT command scripts from ROM, checks replies, retries and captures message indices
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of at_script_sequencer_if (start/select, UART tx/rx, status, message index)
module at_script_sequencer
    import at_seq_pkg::*;
#(
    parameter int                     CMD_DEPTH   = 128,
    parameter int                     NUM_SCRIPTS = 4,
    parameter int                     TOUT_CYCLES = 50_000_000,
    parameter int                     MAX_RETRY   = 3,
    parameter logic [CMD_DEPTH*8-1:0] INIT_DATA   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    at_script_sequencer_if.slave  bus
);
    localparam int AW = $clog2(CMD_DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] addr, addr_nxt, line_start, line_start_nxt;
    logic [7:0]    retry, retry_nxt, tx_data, tx_data_nxt, msg_no, msg_no_nxt, acc, acc_nxt, rom_q;
    logic [31:0]   timer, timer_nxt, win, win_nxt, win_sh;
    logic [11:0]   acc_ext;
    logic          tx_valid, tx_valid_nxt, msg_no_valid, msg_no_valid_nxt;
    logic          cap, cap_nxt, dig, dig_nxt;
    logic          rsp_ok, rsp_err, tout, is_dig;

    // ROM is addressed with the next address so the byte is ready during the single FETCH cycle
    at_cmd_rom #(.DEPTH(CMD_DEPTH), .INIT(INIT_DATA)) u_rom (
        .clk  (clk),
        .addr (addr_nxt),
        .data (rom_q)
    );

    assign bus.tx_data      = tx_data;
    assign bus.tx_valid     = tx_valid;
    assign bus.msg_no       = msg_no;
    assign bus.msg_no_valid = msg_no_valid;
    assign bus.done         = state == DONE;
    assign bus.fail         = state == FAIL;
    assign bus.busy         = !(state inside {IDLE, DONE, FAIL});

    always_comb begin
        state_nxt        = state;
        addr_nxt         = addr;
        line_start_nxt   = line_start;
        retry_nxt        = retry;
        timer_nxt        = timer;
        win_nxt          = win;
        tx_data_nxt      = tx_data;
        tx_valid_nxt     = tx_valid;
        msg_no_nxt       = msg_no;
        msg_no_valid_nxt = 1'b0;
        acc_nxt          = acc;
        cap_nxt          = cap;
        dig_nxt          = dig;
        win_sh  = bus.rx_valid ? {win[23:0], bus.rx_data} : win;
        rsp_ok  = bus.rx_valid && win_sh == RSP_OK;
        rsp_err = bus.rx_valid && win_sh == RSP_ERR;
        tout    = timer == 32'(TOUT_CYCLES - 1);
        is_dig  = bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39;
        acc_ext = 12'(acc) * 12'd10 + 12'(bus.rx_data - 8'h30);
        case (state)
            IDLE: if (bus.start) begin
                addr_nxt       = AW'(script_base(int'(bus.script_sel), CMD_DEPTH, NUM_SCRIPTS));
                line_start_nxt = addr_nxt;
                retry_nxt      = '0;
                state_nxt      = FETCH;
            end
            FETCH: if (rom_q == NUL) begin
                state_nxt = DONE;
            end else begin
                tx_data_nxt  = rom_q;
                tx_valid_nxt = 1'b1;
                state_nxt    = SEND;
            end
            SEND: if (bus.tx_ready) begin
                addr_nxt     = addr + 1'b1;
                tx_valid_nxt = 1'b0;
                state_nxt    = tx_data == CR ? WAIT_RSP : FETCH;
                if (tx_data == CR) begin
                    timer_nxt = '0;
                    win_nxt   = '0;
                    cap_nxt   = 1'b0;
                    dig_nxt   = 1'b0;
                end
            end
            WAIT_RSP: begin
                timer_nxt = timer + 32'd1;
                win_nxt   = win_sh;
                // Index capture: ',' arms it, digits accumulate, CR commits, anything else aborts
                if (bus.rx_valid) begin
                    if (bus.rx_data == COMMA) begin
                        cap_nxt = 1'b1;
                        acc_nxt = '0;
                        dig_nxt = 1'b0;
                    end else if (cap && is_dig) begin
                        acc_nxt = acc_ext > 12'd255 ? 8'hFF : acc_ext[7:0];
                        dig_nxt = 1'b1;
                    end else if (cap && bus.rx_data == CR) begin
                        cap_nxt          = 1'b0;
                        msg_no_nxt       = dig ? acc : msg_no;
                        msg_no_valid_nxt = dig;
                    end else begin
                        cap_nxt = 1'b0;
                    end
                end
                // An OK arriving on the timeout cycle still counts as success
                if (rsp_ok) begin
                    state_nxt = NEXT;
                end else if (rsp_err || tout) begin
                    if (retry < 8'(MAX_RETRY)) begin
                        retry_nxt = retry + 8'd1;
                        addr_nxt  = line_start;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = FAIL;
                    end
                end
            end
            NEXT: begin
                line_start_nxt = addr;
                retry_nxt      = '0;
                state_nxt      = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            line_start   <= '0;
            retry        <= '0;
            timer        <= '0;
            win          <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            msg_no       <= '0;
            msg_no_valid <= 1'b0;
            acc          <= '0;
            cap          <= 1'b0;
            dig          <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr         <= addr_nxt;
            line_start   <= line_start_nxt;
            retry        <= retry_nxt;
            timer        <= timer_nxt;
            win          <= win_nxt;
            tx_data      <= tx_data_nxt;
            tx_valid     <= tx_valid_nxt;
            msg_no       <= msg_no_nxt;
            msg_no_valid <= msg_no_valid_nxt;
            acc          <= acc_nxt;
            cap          <= cap_nxt;
            dig          <= dig_nxt;
        end
    end
endmodule

// File: tb/tb_at_script_sequencer.sv
// tb_at_script_sequencer: directed self-checking bench for at_script_sequencer
module tb_at_script_sequencer;
    // Script 0 @0: "AT\r",0 ; script 1 @32: "ATE0\r" "AT\r",0
    localparam logic [1023:0] ROM_IMG = 1024'({72'h00_0D_54_41_0D_30_45_54_41, 224'h0, 32'h00_0D_54_41});

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    int   n_done = 0, n_fail = 0, n_mv = 0, n_ovl = 0;
    int   nb, cyc, d0, f0, m0;
    logic [7:0] txq [$];

    at_script_sequencer_if #(.SEL_W(2)) b();

    at_script_sequencer #(
        .CMD_DEPTH   (128),
        .NUM_SCRIPTS (4),
        .TOUT_CYCLES (100),
        .MAX_RETRY   (3),
        .INIT_DATA   (ROM_IMG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    // Handshakes and pulses are observed on the falling edge, half a cycle from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (b.tx_valid && b.tx_ready) txq.push_back(b.tx_data);
            n_done += int'(b.done);
            n_fail += int'(b.fail);
            n_mv   += int'(b.msg_no_valid);
            if ((b.done || b.fail) && b.busy) n_ovl++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input int n, output int c);
        c = 0;
        while (txq.size() < n && c < 2000) begin
            tick(1);
            c++;
        end
        chk("tx_wait", 32'(txq.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (b.busy && c < 2000) begin
            tick(1);
            c++;
        end
        chk("idle_wait", 32'(b.busy), 32'd0);
        tick(2);
    endtask

    task automatic rx_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            b.rx_data  = s[i];
            b.rx_valid = 1'b1;
            tick(1);
        end
        b.rx_valid = 1'b0;
        tick(1);
    endtask

    task automatic go(input logic [1:0] sel);
        b.script_sel = sel;
        b.start      = 1'b1;
        tick(1);
        b.start      = 1'b0;
    endtask

    initial begin
        b.start = 1'b0; b.script_sel = '0; b.tx_ready = 1'b1; b.rx_data = '0; b.rx_valid = 1'b0;
        tick(3);
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_tx_valid", 32'(b.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(b.tx_data), 32'd0);
        chk("rst_done", 32'(b.done), 32'd0);
        chk("rst_fail", 32'(b.fail), 32'd0);
        chk("rst_msg_no", 32'(b.msg_no), 32'd0);
        chk("rst_msg_no_valid", 32'(b.msg_no_valid), 32'd0);
        rst = 1'b0;
        tick(1);

        // Plain "AT\r" answered OK
        go(2'd0);
        chk("busy_after_start", 32'(b.busy), 32'd1);
        wait_tx(3, cyc);
        chk("at_b0", 32'(txq[0]), 32'h41);
        chk("at_b1", 32'(txq[1]), 32'h54);
        chk("at_b2", 32'(txq[2]), 32'h0D);
        rx_str("OK\r\n");
        wait_idle();
        chk("at_done", 32'(n_done), 32'd1);
        chk("at_nofail", 32'(n_fail), 32'd0);
        chk("at_bytes", 32'(txq.size()), 32'd3);
        nb = 3;

        // Two ERROR replies then OK: line sent three times
        go(2'd0);
        wait_tx(nb + 3, cyc);
        rx_str("ERROR\r\n");
        wait_tx(nb + 6, cyc);
        chk("err_resend_b0", 32'(txq[nb+3]), 32'h41);
        rx_str("ERROR\r\n");
        wait_tx(nb + 9, cyc);
        chk("err_resend_b2", 32'(txq[nb+8]), 32'h0D);
        rx_str("OK\r\n");
        wait_idle();
        chk("err_done", 32'(n_done), 32'd2);
        chk("err_nofail", 32'(n_fail), 32'd0);
        chk("err_bytes", 32'(txq.size()), 32'(nb + 9));
        nb += 9;

        // Silence: first timeout is 100 cycles in WAIT_RSP, fail after the 4th
        go(2'd0);
        wait_tx(nb + 3, cyc);
        wait_tx(nb + 4, cyc);
        chk("tout_latency", 32'(cyc), 32'd102);
        wait_tx(nb + 12, cyc);
        wait_idle();
        chk("tout_fail", 32'(n_fail), 32'd1);
        chk("tout_nodone", 32'(n_done), 32'd2);
        chk("tout_bytes", 32'(txq.size()), 32'(nb + 12));
        nb += 12;

        // Message index capture, abort on non-digit, saturation
        go(2'd0);
        wait_tx(nb + 3, cyc);
        rx_str("+CMTI: \"SM\",12\r\n");
        chk("msg_12", 32'(b.msg_no), 32'd12);
        chk("msg_12_pulse", 32'(n_mv), 32'd1);
        rx_str(",1x\r\n");
        chk("msg_abort_keep", 32'(b.msg_no), 32'd12);
        chk("msg_abort_nopulse", 32'(n_mv), 32'd1);
        rx_str(",300\r\n");
        chk("msg_sat", 32'(b.msg_no), 32'd255);
        chk("msg_sat_pulse", 32'(n_mv), 32'd2);
        rx_str("OK\r\n");
        wait_idle();
        chk("msg_done", 32'(n_done), 32'd3);
        nb += 3;

        // Backpressure, ignored start while busy, two-line script with retry on line 2
        b.tx_ready = 1'b0;
        go(2'd1);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            b.start = (i == 0);
            chk("hold_valid", 32'(b.tx_valid), 32'd1);
            chk("hold_data", 32'(b.tx_data), 32'h41);
            tick(1);
        end
        b.start = 1'b0;
        b.tx_ready = 1'b1;
        wait_tx(nb + 5, cyc);
        chk("s1_b2", 32'(txq[nb+2]), 32'h45);
        chk("s1_b3", 32'(txq[nb+3]), 32'h30);
        chk("s1_b4", 32'(txq[nb+4]), 32'h0D);
        rx_str("OK\r\n");
        wait_tx(nb + 8, cyc);
        chk("s1_l2_b0", 32'(txq[nb+5]), 32'h41);
        chk("s1_l2_b2", 32'(txq[nb+7]), 32'h0D);
        rx_str("ERROR\r\n");
        wait_tx(nb + 11, cyc);
        chk("s1_retry_b1", 32'(txq[nb+9]), 32'h54);
        chk("s1_retry_b2", 32'(txq[nb+10]), 32'h0D);
        rx_str("OK\r\n");
        wait_idle();
        chk("s1_done", 32'(n_done), 32'd4);
        chk("s1_bytes", 32'(txq.size()), 32'(nb + 11));
        nb += 11;

        // Reset while waiting for a reply
        go(2'd0);
        wait_tx(nb + 3, cyc);
        d0 = n_done; f0 = n_fail; m0 = n_mv;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("rst_mid_busy", 32'(b.busy), 32'd0);
        chk("rst_mid_tx_valid", 32'(b.tx_valid), 32'd0);
        chk("rst_mid_msg_no", 32'(b.msg_no), 32'd0);
        chk("rst_mid_nodone", 32'(n_done), 32'(d0));
        chk("rst_mid_nofail", 32'(n_fail), 32'(f0));
        nb += 3;
        go(2'd0);
        wait_tx(nb + 3, cyc);
        chk("restart_b0", 32'(txq[nb]), 32'h41);
        chk("restart_b1", 32'(txq[nb+1]), 32'h54);
        rx_str("OK\r\n");
        wait_idle();
        chk("restart_done", 32'(n_done), 32'(d0 + 1));
        chk("restart_nomsg", 32'(n_mv), 32'(m0));
        chk("busy_low_on_pulse", 32'(n_ovl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/at_script_sequencer.md
AT_SCRIPT_SEQUENCER -- requirements
Module: at_script_sequencer

Interface
REQ-001 Parameter CMD_DEPTH, default 128, command-ROM depth in bytes (power of two).
REQ-002 Parameter NUM_SCRIPTS, default 4, number of scripts; each owns CMD_DEPTH/NUM_SCRIPTS bytes.
REQ-003 Parameter TOUT_CYCLES, default 50_000_000, response timeout in clk cycles.
REQ-004 Parameter MAX_RETRY, default 3, retries allowed per command line.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request to run the selected script.
REQ-008 script_sel  in  clog2(NUM_SCRIPTS)  script index, sampled on accepted start.
REQ-009 tx_data  out  8  byte to UART transmitter.
REQ-010 tx_valid  out  1  tx_data valid; held until tx_ready.
REQ-011 tx_ready  in  1  UART transmitter accepts byte when tx_valid&tx_ready.
REQ-012 rx_data  in  8  byte from UART receiver.
REQ-013 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-014 busy  out  1  high from accepted start until done/fail pulse.
REQ-015 done  out  1  one-cycle pulse: script completed, every line answered OK.
REQ-016 fail  out  1  one-cycle pulse: retries exhausted.
REQ-017 msg_no  out  8  last captured message index.
REQ-018 msg_no_valid  out  1  one-cycle pulse when msg_no updates.

Function
REQ-019 States IDLE, FETCH, SEND, WAIT_RSP, NEXT, DONE, FAIL; encoding fixed in package.
REQ-020 IDLE: start accepted only in IDLE; address <= script_sel*(CMD_DEPTH/NUM_SCRIPTS), line_start <= same, retry <= 0, -> FETCH; start outside IDLE ignored.
REQ-021 FETCH: ROM read latency is one cycle; byte 0x00 -> DONE; otherwise -> SEND with tx_data=byte, tx_valid=1.
REQ-022 SEND: on tx_valid&tx_ready, address+1; byte 0x0D -> WAIT_RSP (clear timer, clear match window); else -> FETCH.
REQ-023 WAIT_RSP: 4-byte shift window over rx bytes; 4F 4B 0D 0A ("OK\r\n") -> NEXT; 4F 52 0D 0A ("OR\r\n", tail of ERROR) -> retry path.
REQ-024 Timer increments each WAIT_RSP cycle; reaching TOUT_CYCLES-1 -> retry path.
REQ-025 Retry path: retry<MAX_RETRY -> retry+1, address <= line_start, -> FETCH; else -> FAIL.
REQ-026 NEXT: line_start <= address, retry <= 0, -> FETCH.
REQ-027 Index capture in WAIT_RSP: after ',' (0x2C), ASCII digits accumulate msg_no_acc = acc*10+digit, saturating at 255; terminating 0x0D with >=1 digit loads msg_no and pulses msg_no_valid; non-digit aborts capture.
REQ-028 Simultaneous OK match and timeout expiry in same cycle: match wins.
REQ-029 DONE/FAIL: pulse done/fail one cycle, busy low same cycle, -> IDLE.
REQ-030 Address wrap beyond a script's region is not checked; ROM content guarantees 0x00 terminator.
REQ-031 tx_valid deasserts only after handshake; tx_data stable while tx_valid high.

Reset
REQ-032 rst: state IDLE; tx_valid, busy, done, fail, msg_no_valid = 0; msg_no, tx_data, timer, retry, address = 0.
REQ-033 rst mid-script aborts immediately; no done/fail pulse; next start restarts from script base.

Structure
REQ-034 Package at_seq_pkg holds state enum, ASCII constants (CR, LF, COMMA, NUL, 'O','K','R') and script-base function.
REQ-035 One sub-module at_cmd_rom: synchronous single-port ROM, CMD_DEPTH x 8, init file parameter.

Verification
REQ-036 Script 0 = "AT\r",0x00; start, tx_ready=1, reply "OK\r\n" -> tx bytes 41 54 0D, one done pulse, busy 0.
REQ-037 Reply "ERROR\r\n" twice then "OK\r\n", MAX_RETRY=3 -> "AT\r" sent 3 times, done pulses.
REQ-038 TOUT_CYCLES=100, no reply -> 4 transmissions of line, fail pulses at 4th timeout.
REQ-039 Reply "+CMTI: \"SM\",12\r\n" then "OK\r\n" -> msg_no=12, msg_no_valid one pulse; ",300\r" -> msg_no=255.
REQ-040 tx_ready low 5 cycles -> tx_data/tx_valid held; rst asserted in WAIT_RSP -> IDLE, no pulses; start during busy ignored.
